reg_file: RTL and testbench

- 32-entry RISC-V integer register file for the single-cycle core.
- Supplies the two ALU operands (rs1, rs2) and accepts the ALU/writeback result (rd).
- It is the other end of the ALU datapath: the source of in_data1/in_data2 and the sink of out_data.
- Storage is sequential and state-holding: x0 is hardwired to zero, reset is asynchronous, and an optional same-cycle write-to-read bypass is provided.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/reg_file.sv | 61 ++++++
 tb/tb_reg_file.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, register addressing and ABI register indices.
// Used by the register file, ALU, decoder and core top.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd1;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;
  localparam logic [REG_ADDR_W-1:0] REG_GP   = 5'd3;

  localparam logic [XLEN-1:0] SP_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports, one clocked write port,
// x0 hardwired to zero, asynchronous reset with a configurable stack-pointer value.
module reg_file
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter int unsigned     NUM_REGS = 32,
  parameter logic [XLEN-1:0] SP_RESET = SP_RESET_DEFAULT,
  parameter bit              BYPASS   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]       in_rd_data,
  input  logic                  in_wr_en,
  output logic [XLEN-1:0]       out_rs1_data,
  output logic [XLEN-1:0]       out_rs2_data
);

  localparam logic [REG_ADDR_W:0] AddrLimit = (REG_ADDR_W + 1)'(NUM_REGS);

  // x0 has no storage; entries start at index 1.
  logic [XLEN-1:0] regs_q [1:NUM_REGS-1];
  logic            wr_ok;

  function automatic logic addr_valid(input logic [REG_ADDR_W-1:0] addr);
    return (addr != REG_ZERO) && ({1'b0, addr} < AddrLimit);
  endfunction

  // Gated by rst so that neither storage nor the bypass path sees a write during reset.
  assign wr_ok = in_wr_en && !rst && addr_valid(in_rd_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      end
    end else if (wr_ok) begin
      regs_q[in_rd_addr] <= in_rd_data;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    logic [XLEN-1:0] data;
    data = '0;
    if (addr_valid(addr)) begin
      if (BYPASS && wr_ok && (in_rd_addr == addr)) begin
        data = in_rd_data;
      end else begin
        data = regs_q[addr];
      end
    end
    return data;
  endfunction

  assign out_rs1_data = read_port(in_rs1_addr);
  assign out_rs2_data = read_port(in_rs2_addr);

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a bypassing and a non-bypassing instance share stimulus;
// expected values are queued as stimulus is driven and popped when outputs are sampled.
module tb_reg_file;

  localparam logic [31:0] SpVal = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] wdata;
  logic        wr_en;
  logic [31:0] byp_rs1, byp_rs2, nb_rs1, nb_rs2;

  reg_file #(
    .XLEN     (32),
    .NUM_REGS (32),
    .SP_RESET (SpVal),
    .BYPASS   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_rs1_addr  (rs1),
    .in_rs2_addr  (rs2),
    .in_rd_addr   (rd),
    .in_rd_data   (wdata),
    .in_wr_en     (wr_en),
    .out_rs1_data (byp_rs1),
    .out_rs2_data (byp_rs2)
  );

  reg_file #(
    .XLEN     (32),
    .NUM_REGS (32),
    .SP_RESET (SpVal),
    .BYPASS   (1'b0)
  ) dut_nb (
    .clk          (clk),
    .rst          (rst),
    .in_rs1_addr  (rs1),
    .in_rs2_addr  (rs2),
    .in_rd_addr   (rd),
    .in_rd_data   (wdata),
    .in_wr_en     (wr_en),
    .out_rs1_data (nb_rs1),
    .out_rs2_data (nb_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output selectors for scoreboard entries.
  localparam int SelB1 = 0, SelB2 = 1, SelN1 = 2, SelN2 = 3, SelSlt = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SelB1:   return byp_rs1;
      SelB2:   return byp_rs2;
      SelN1:   return nb_rs1;
      SelN2:   return nb_rs2;
      default: return {31'b0, $signed(byp_rs1) < $signed(byp_rs2)};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = pick(e.sel);
      tests++;
      assert (obs === e.exp)
      else begin
        fails++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    rs1   = '0;
    rs2   = '0;
    rd    = '0;
    wdata = '0;
    wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Populate x5, then assert reset between edges and read without any clock edge.
    rd = 5'd5; wdata = 32'hDEAD_BEEF; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; rs1 = 5'd5;
    #1;
    push("x5_written", SelB1, 32'hDEAD_BEEF);
    check();
    @(negedge clk);
    rst = 1'b1; rs2 = 5'd2;
    #1;
    push("rst_async_x5", SelB1, 32'h0);
    push("rst_async_sp", SelB2, SpVal);
    push("rst_async_sp_nb", SelN2, SpVal);
    check();
    for (int a = 0; a < 32; a++) begin
      rs1 = 5'(a);
      #1;
      push($sformatf("rst_sweep_x%0d", a), SelB1, (a == 2) ? SpVal : 32'h0);
      check();
    end
    @(negedge clk);
    rst = 1'b0;

    // Basic writes and signed compare of the read operands.
    rd = 5'd3; wdata = 32'd7; wr_en = 1'b1;
    tick();
    rd = 5'd4; wdata = 32'hFFFF_FFF6;
    tick();
    wr_en = 1'b0; rs1 = 5'd3; rs2 = 5'd4;
    #1;
    push("rd_x3", SelB1, 32'd7);
    push("rd_x4", SelB2, 32'hFFFF_FFF6);
    push("rd_x3_nb", SelN1, 32'd7);
    check();
    rs1 = 5'd4; rs2 = 5'd3;
    #1;
    push("slt_x4_x3", SelSlt, 32'd1);
    check();

    // Writes to x0 never appear, even through the bypass path.
    rd = 5'd0; wdata = 32'h1234_5678; wr_en = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    push("x0_bypass", SelB1, 32'h0);
    push("x0_bypass_p2", SelB2, 32'h0);
    check();
    tick();
    push("x0_after_edge", SelB1, 32'h0);
    push("x0_after_edge_nb", SelN1, 32'h0);
    check();

    // Same-cycle bypass on both ports versus stored value without bypass.
    rd = 5'd6; wdata = 32'd1; wr_en = 1'b1;
    tick();
    wdata = 32'd32; rs1 = 5'd6; rs2 = 5'd6;
    #1;
    push("byp_rs1", SelB1, 32'd32);
    push("byp_rs2", SelB2, 32'd32);
    push("nobyp_rs1", SelN1, 32'd1);
    push("nobyp_rs2", SelN2, 32'd1);
    check();
    tick();
    wr_en = 1'b0;
    #1;
    push("byp_after", SelB1, 32'd32);
    push("nobyp_after", SelN1, 32'd32);
    push("nobyp_after_p2", SelN2, 32'd32);
    check();

    // Write enable low: no state change across several edges.
    rd = 5'd9; wdata = 32'hFFFF_FFFF; wr_en = 1'b0; rs1 = 5'd9; rs2 = 5'd6;
    repeat (3) tick();
    push("wr_en_low_x9", SelB1, 32'h0);
    push("wr_en_low_x9_nb", SelN1, 32'h0);
    push("wr_en_low_x6", SelB2, 32'd32);
    check();

    // Reset raised mid-stream between edges and held across an edge with a write pending.
    rs1 = 5'd10; rs2 = 5'd2;
    rd = 5'd10; wdata = 32'd1; wr_en = 1'b1;
    tick();
    wdata = 32'd2;
    tick();
    wdata = 32'd3;
    #2;
    rst = 1'b1;
    #1;
    push("rst_mid_x10", SelB1, 32'h0);
    push("rst_mid_x10_nb", SelN1, 32'h0);
    push("rst_mid_sp", SelB2, SpVal);
    check();
    wdata = 32'd4;
    tick();
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rs2 = 5'd3;
    #1;
    push("post_rst_x10", SelB1, 32'h0);
    push("post_rst_x10_nb", SelN1, 32'h0);
    push("post_rst_x3", SelB2, 32'h0);
    check();

    // Writes resume after reset.
    wdata = 32'd5; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    #1;
    push("resume_x10", SelB1, 32'd5);
    push("resume_x10_nb", SelN1, 32'd5);
    check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
